mux4way16: RTL and testbench
============================

// Module: mux4way16
// PURPOSE
// - 4-way, WIDTH-bit (default 16) word multiplexer; a 2-bit select picks one of four data words.
// - Primary output `out` is purely combinational.
// - A registered copy (`out_q`) is provided for pipelined consumers.
// - Datapath building block (ALU operand / register-file read select).
// PARAMETERS
// - WIDTH  16  data word width in bits (a, b, c, d, out, out_q)
// PORTS
// - clk    in   1      single system clock; all registers update on rising edge
// - rst_n  in   1      reset, synchronous, active-low
// - a      in   WIDTH  data word selected when sel=2'b00
// - b      in   WIDTH  data word selected when sel=2'b01
// - c      in   WIDTH  data word selected when sel=2'b10
// - d      in   WIDTH  data word selected when sel=2'b11
// - sel    in   2      select
// - out    out  WIDTH  combinational selected word
// - out_q  out  WIDTH  registered selected word
// BEHAVIOUR
// - Combinational path (out):
//   - out = (sel==0)?a : (sel==1)?b : (sel==2)?c : d.
//   - Zero latency; out tracks input/sel changes within the same delta.
//   - No clock or reset dependency.
// - X/Z on sel: out is don't-care in RTL sim; synthesis treats sel as 2-state.
// - Registered path (out_q):
//   - On each rising clk edge with rst_n=0: out_q <= 0.
//   - On each rising clk edge with rst_n=1: out_q <= current out value.
//   - Latency: exactly 1 cycle. No enable; it captures every cycle.
// - Reset:
//   - Synchronous only. Asserting rst_n low between edges has no effect until the next rising edge.
//   - out is unaffected by reset.
// - Reset values: out_q = 0. out has no reset value (combinational).
// - Simultaneous sel and data changes before an edge: out_q captures the settled combinational value at that edge.
// - Widths are exact: no extension or truncation; all data ports are WIDTH bits.
// CONFIGURATION
// - Macro MUX4WAY16_PARITY_EN.
// - When defined, two extra ports exist:
//   - out_par    out  1  combinational even parity, out_par = ^out
//   - out_par_q  out  1  registered out_par; 1-cycle latency; reset to 0 with rst_n=0
// - When undefined: neither port exists; no parity logic is built.
// - Data-path behaviour is identical in both builds.
// TESTING
// 1. All inputs 0; sel=0,1,2,3 -> out=0x0000 for every sel.
// 2. a=0x1234, b=0x9876, c=0xAAAA, d=0x5555; sweep sel=0,1,2,3 -> out=0x1234, 0x9876, 0xAAAA, 0x5555.
//    Decimal display: 4660, 39030, 43690, 21845. Checked after #1 settle, no clock required.
// 3. rst_n=0 for 2 edges -> out_q=0x0000.
//    Release rst_n; sel=1 with the vectors of test 2 -> out_q=0x9876 exactly one edge later.
// 4. With rst_n=1, change sel 2->3 mid-cycle:
//    - out switches 0xAAAA->0x5555 immediately.
//    - out_q holds 0xAAAA until the next edge.
// 5. rst_n driven low between edges while out_q=0x5555:
//    - out_q holds until the next rising edge, then becomes 0.
//    - out stays 0x5555 throughout.
// 6. MUX4WAY16_PARITY_EN defined, d=0x5555, sel=3:
//    - out_par=0 (eight ones).
//    - Then a=0x0001, sel=0 -> out_par=1; out_par_q follows one edge later.

Source files
------------

// File: rtl/mux4way16.sv
// mux4way16: 4-way WIDTH-bit word multiplexer with a combinational output
// and a one-cycle registered copy for pipelined consumers.
// Optional even-parity outputs are built when MUX4WAY16_PARITY_EN is defined.
module mux4way16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
`ifdef MUX4WAY16_PARITY_EN
  output logic             out_par,
  output logic             out_par_q,
`endif
  output logic [WIDTH-1:0] out_q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // Word select; sel is treated as 2-state, so d covers the last code.
  always_comb begin
    out = d;
    case (sel)
      2'b00:   out = a;
      2'b01:   out = b;
      2'b10:   out = c;
      default: out = d;
    endcase
  end

  // Next registered value is simply the settled mux output.
  always_comb begin
    data_d = out;
  end

  // One-cycle copy of the selected word, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign out_q = data_q;

`ifdef MUX4WAY16_PARITY_EN
  logic par_d;
  logic par_q;

  // Even parity of the combinational output.
  always_comb begin
    par_d = ^out;
  end

  assign out_par = par_d;

  // Registered parity, aligned with out_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign out_par_q = par_q;
`endif

endmodule

// File: tb/tb_mux4way16.sv
// Directed self-checking bench for mux4way16 (combinational and registered paths,
// synchronous reset timing; parity outputs when MUX4WAY16_PARITY_EN is defined).
module tb_mux4way16;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a, b, c, d;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
`ifdef MUX4WAY16_PARITY_EN
  logic             out_par;
  logic             out_par_q;
`endif

  int total = 0;
  int bad   = 0;

  mux4way16 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .sel      (sel),
    .out      (out),
`ifdef MUX4WAY16_PARITY_EN
    .out_par  (out_par),
    .out_par_q(out_par_q),
`endif
    .out_q    (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] got,
                     input logic [WIDTH-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%04h expected=0x%04h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] sweep_exp [4];

  initial begin
    rst_n = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    sel = 2'd0;
    #1;

    // All-zero inputs: every select gives zero.
    for (int i = 0; i < 4; i++) begin
      sel = i[1:0];
      #1;
      chk($sformatf("zero_sel%0d", i), out, 16'h0000);
    end

    // Two edges in reset clear the register.
    tick();
    tick();
    chk("reset_out_q", out_q, 16'h0000);

    // Distinct vectors, combinational sweep (still in reset, no clock needed).
    a = 16'h1234; b = 16'h9876; c = 16'hAAAA; d = 16'h5555;
    sweep_exp[0] = 16'h1234; sweep_exp[1] = 16'h9876;
    sweep_exp[2] = 16'hAAAA; sweep_exp[3] = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      sel = i[1:0];
      #1;
      chk($sformatf("sweep_sel%0d", i), out, sweep_exp[i]);
    end
    chk("reset_hold_out_q", out_q, 16'h0000);

    // Release reset, select b: out_q updates exactly one edge later.
    rst_n = 1'b1;
    sel = 2'd1;
    #1;
    chk("pre_edge_out_q", out_q, 16'h0000);
    tick();
    chk("lat1_out_q", out_q, 16'h9876);

    // sel 2 registered, then sel 3 mid-cycle.
    sel = 2'd2;
    tick();
    chk("sel2_out_q", out_q, 16'hAAAA);
    #2;
    sel = 2'd3;
    #1;
    chk("mid_sel3_out", out, 16'h5555);
    chk("mid_sel3_out_q_hold", out_q, 16'hAAAA);
    tick();
    chk("sel3_out_q", out_q, 16'h5555);

    // Reset asserted between edges: no effect until the next edge.
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_q_hold", out_q, 16'h5555);
    chk("rst_mid_out", out, 16'h5555);
    tick();
    chk("rst_edge_out_q", out_q, 16'h0000);
    chk("rst_edge_out", out, 16'h5555);

    // Simultaneous data and select change before an edge.
    rst_n = 1'b1;
    tick();
    chk("rel_out_q", out_q, 16'h5555);
    a = 16'hBEEF;
    sel = 2'd0;
    #1;
    chk("simul_out", out, 16'hBEEF);
    c = 16'h0F0F;
    sel = 2'd2;
    tick();
    chk("simul_out_q", out_q, 16'h0F0F);

`ifdef MUX4WAY16_PARITY_EN
    d = 16'h5555;
    sel = 2'd3;
    #1;
    chk("par_5555", {15'd0, out_par}, 16'd0);
    tick();
    chk("par_q_5555", {15'd0, out_par_q}, 16'd0);
    a = 16'h0001;
    sel = 2'd0;
    #1;
    chk("par_0001", {15'd0, out_par}, 16'd1);
    chk("par_q_hold", {15'd0, out_par_q}, 16'd0);
    tick();
    chk("par_q_0001", {15'd0, out_par_q}, 16'd1);
    rst_n = 1'b0;
    tick();
    chk("par_q_reset", {15'd0, out_par_q}, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net: the directed sequence is short; never run away.
  initial begin
    #5000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
